// File: rtl/svga_timing_param_if.sv
// Video timing bundle between the timing generator and the fetch/display pipeline.
// Latency: n/a (signal grouping only).
// Backpressure: none; timing is free-running and consumers must keep up.
interface svga_timing_param_if;
  logic [1:0]  v_scale;
  logic        h_synch;
  logic        v_synch;
  logic        h_blank;
  logic        v_blank;
  logic        blank;
  logic        frame_start;
  logic        line_start;
  logic        show_border;
  logic        fetch_en;
  logic [11:0] pixel_count;
  logic [10:0] line_count;
  logic [4:0]  subchar_pixel;
  logic [6:0]  char_column;
  logic [4:0]  subchar_line;
  logic [6:0]  char_line;
  logic [9:0]  graph_pixel;
  logic [8:0]  graph_line;

  // Timing generator side
  modport master (
    input  v_scale,
    output h_synch, v_synch, h_blank, v_blank, blank, frame_start, line_start,
           show_border, fetch_en, pixel_count, line_count, subchar_pixel,
           char_column, subchar_line, char_line, graph_pixel, graph_line
  );

  // Consumer side
  modport slave (
    output v_scale,
    input  h_synch, v_synch, h_blank, v_blank, blank, frame_start, line_start,
           show_border, fetch_en, pixel_count, line_count, subchar_pixel,
           char_column, subchar_line, char_line, graph_pixel, graph_line
  );
endinterface

// File: rtl/svga_timing_param.sv
// Parametrised VESA-style timing generator with window, fetch lead and cell/graphics counters.
// Latency: every output is registered and matches pixel_count/line_count of the same cycle.
// Backpressure: none; free-running on pixel_clock, fetch_en leads the window by LEAD pixels.
module svga_timing_param #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int WIN_X    = 64,
  parameter int WIN_Y    = 48,
  parameter int WIN_W    = 512,
  parameter int WIN_H    = 384,
  parameter int LEAD     = 7,
  parameter int CHAR_W   = 16,
  parameter int CHAR_H   = 24
) (
  input  logic                   pixel_clock,
  input  logic                   reset,
  svga_timing_param_if.master    vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Horizontal decode points (end points are exclusive)
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] HB_BEG = 12'(H_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] WX_BEG = 12'(WIN_X);
  localparam logic [11:0] WX_END = 12'(WIN_X + WIN_W);
  localparam logic [11:0] FE_BEG = 12'(WIN_X - LEAD);
  localparam logic [11:0] FE_END = 12'(WIN_X + WIN_W - LEAD);

  // Vertical decode points (end points are exclusive)
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] VB_BEG = 11'(V_ACTIVE);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] WY_BEG = 11'(WIN_Y);
  localparam logic [10:0] WY_END = 11'(WIN_Y + WIN_H);

  localparam logic [4:0] CW_LAST = 5'(CHAR_W - 1);
  localparam logic [4:0] CH_LAST = 5'(CHAR_H - 1);

  logic [11:0] pix_q, pix_d;
  logic [10:0] line_q, line_d;

  logic win_line_d, in_win_d, fetch_d, hblank_d, vblank_d, hsync_d, vsync_d;
  logic line_start_d, frame_start_d, first_win_d, later_win_d;

  logic h_synch_q, v_synch_q, h_blank_q, v_blank_q, blank_q;
  logic frame_start_q, line_start_q, show_border_q, fetch_q;

  logic [4:0] subpix_q;
  logic [6:0] col_q;
  logic [9:0] gpix_q;
  logic [4:0] subline_q;
  logic [6:0] cline_q;
  logic [8:0] gline_q;
  logic [1:0] phase_q;
  logic [1:0] last_phase_q;   // latched scale minus one: 0=1x, 1=2x, 2=3x

  // Next raster position; all outputs decode from it so they line up with the counters
  always_comb begin
    pix_d  = pix_q + 12'd1;
    line_d = line_q;
    if (pix_q == H_LAST) begin
      pix_d  = 12'd0;
      line_d = (line_q == V_LAST) ? 11'd0 : line_q + 11'd1;
    end
  end

  // Region decode of the next position
  always_comb begin
    win_line_d    = (line_d >= WY_BEG) && (line_d < WY_END);
    in_win_d      = win_line_d && (pix_d >= WX_BEG) && (pix_d < WX_END);
    fetch_d       = win_line_d && (pix_d >= FE_BEG) && (pix_d < FE_END);
    hblank_d      = pix_d >= HB_BEG;
    vblank_d      = line_d >= VB_BEG;
    hsync_d       = (pix_d >= HS_BEG) && (pix_d < HS_END);
    vsync_d       = (line_d >= VS_BEG) && (line_d < VS_END);
    line_start_d  = pix_d == 12'd0;
    frame_start_d = line_start_d && (line_d == 11'd0);
    first_win_d   = line_start_d && (line_d == WY_BEG);
    later_win_d   = line_start_d && win_line_d && (line_d != WY_BEG);
  end

  // Raster counters and registered sync/blank/window flags
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      pix_q         <= 12'd0;
      line_q        <= 11'd0;
      h_synch_q     <= !HS_POL;
      v_synch_q     <= !VS_POL;
      h_blank_q     <= 1'b0;
      v_blank_q     <= 1'b0;
      blank_q       <= 1'b0;
      frame_start_q <= 1'b0;
      line_start_q  <= 1'b0;
      show_border_q <= 1'b1;
      fetch_q       <= 1'b0;
    end else begin
      pix_q         <= pix_d;
      line_q        <= line_d;
      h_synch_q     <= hsync_d ? HS_POL : !HS_POL;
      v_synch_q     <= vsync_d ? VS_POL : !VS_POL;
      h_blank_q     <= hblank_d;
      v_blank_q     <= vblank_d;
      blank_q       <= hblank_d | vblank_d;
      frame_start_q <= frame_start_d;
      line_start_q  <= line_start_d;
      show_border_q <= !(hblank_d | vblank_d) && !in_win_d;
      fetch_q       <= fetch_d;
    end
  end

  // Horizontal cell/graphics counters: count fetch cycles already issued on this line
  always_ff @(posedge pixel_clock) begin
    if (reset || line_start_d) begin
      subpix_q <= 5'd0;
      col_q    <= 7'd0;
      gpix_q   <= 10'd0;
    end else if (fetch_q) begin
      gpix_q <= gpix_q + 10'd1;
      if (subpix_q == CW_LAST) begin
        subpix_q <= 5'd0;
        col_q    <= col_q + 7'd1;
      end else begin
        subpix_q <= subpix_q + 5'd1;
      end
    end
  end

  // Graphics scale latch: v_scale only takes effect at a frame boundary
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      last_phase_q <= 2'd0;
    end else if (frame_start_d) begin
      last_phase_q <= (vid.v_scale == 2'd3) ? 2'd0 : vid.v_scale;
    end
  end

  // Vertical cell/graphics counters: step once per window line, hold elsewhere
  always_ff @(posedge pixel_clock) begin
    if (reset || first_win_d) begin
      subline_q <= 5'd0;
      cline_q   <= 7'd0;
      gline_q   <= 9'd0;
      phase_q   <= 2'd0;
    end else if (later_win_d) begin
      if (subline_q == CH_LAST) begin
        subline_q <= 5'd0;
        cline_q   <= cline_q + 7'd1;
      end else begin
        subline_q <= subline_q + 5'd1;
      end
      if (phase_q == last_phase_q) begin
        phase_q <= 2'd0;
        gline_q <= gline_q + 9'd1;
      end else begin
        phase_q <= phase_q + 2'd1;
      end
    end
  end

  assign vid.h_synch       = h_synch_q;
  assign vid.v_synch       = v_synch_q;
  assign vid.h_blank       = h_blank_q;
  assign vid.v_blank       = v_blank_q;
  assign vid.blank         = blank_q;
  assign vid.frame_start   = frame_start_q;
  assign vid.line_start    = line_start_q;
  assign vid.show_border   = show_border_q;
  assign vid.fetch_en      = fetch_q;
  assign vid.pixel_count   = pix_q;
  assign vid.line_count    = line_q;
  assign vid.subchar_pixel = subpix_q;
  assign vid.char_column   = col_q;
  assign vid.subchar_line  = subline_q;
  assign vid.char_line     = cline_q;
  assign vid.graph_pixel   = gpix_q;
  assign vid.graph_line    = gline_q;

endmodule

// File: tb/tb_svga_timing_param.sv
// Bench for svga_timing_param on a reduced mode so several frames fit in a short run.
// Latency: expected outputs are pushed at each edge and compared on the following falling edge.
// Backpressure: none; the DUT is free-running.
module tb_svga_timing_param;

  localparam int HA = 40, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 30, VFP = 2, VSW = 2, VBP = 4;
  localparam bit HSP = 1'b0, VSP = 1'b1;
  localparam int WX = 8, WY = 4, WW = 24, WH = 18, LD = 3;
  localparam int CW = 4, CH = 6;
  localparam int HT = HA + HFP + HSW + HBP;   // 56
  localparam int VT = VA + VFP + VSW + VBP;   // 38
  localparam int STEP_LIMIT = 40000;

  logic pixel_clock = 1'b0;
  logic reset;

  svga_timing_param_if vif ();

  svga_timing_param #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(HSP), .VS_POL(VSP),
    .WIN_X(WX), .WIN_Y(WY), .WIN_W(WW), .WIN_H(WH),
    .LEAD(LD), .CHAR_W(CW), .CHAR_H(CH)
  ) dut (
    .pixel_clock(pixel_clock),
    .reset      (reset),
    .vid        (vif)
  );

  always #5 pixel_clock = ~pixel_clock;

  typedef struct {
    logic [79:0] v;
    bit          rst;
  } exp_t;

  exp_t sbq[$];

  int total = 0;
  int bad   = 0;
  int chk_cyc = 0;
  int anchor = -1;
  int nfs_obs = 0;
  int nfs_exp = 0;

  // reference model state
  int m_pix, m_line, m_scale, m_fr;
  int held_sl, held_cl, held_gl;

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", tag, chk_cyc, obs, exp);
    end
  endtask

  function automatic logic [79:0] pack(
    input bit hs, input bit vs, input bit hb, input bit vb, input bit bl,
    input bit fs, input bit ls, input bit sb, input bit fe,
    input int pc, input int lc, input int sp, input int cc,
    input int sl, input int cl, input int gp, input int gl);
    return {5'd0, hs, vs, hb, vb, bl, fs, ls, sb, fe,
            12'(pc), 11'(lc), 5'(sp), 7'(cc), 5'(sl), 7'(cl), 10'(gp), 9'(gl)};
  endfunction

  function automatic logic [79:0] observed();
    return pack(vif.h_synch, vif.v_synch, vif.h_blank, vif.v_blank, vif.blank,
                vif.frame_start, vif.line_start, vif.show_border, vif.fetch_en,
                int'(vif.pixel_count), int'(vif.line_count),
                int'(vif.subchar_pixel), int'(vif.char_column),
                int'(vif.subchar_line), int'(vif.char_line),
                int'(vif.graph_pixel), int'(vif.graph_line));
  endfunction

  // Advance the model by one clock edge and queue the outputs the DUT must show
  task automatic model_step(input bit r, input logic [1:0] vs);
    exp_t e;
    bit win, hs, vsy, hb, vb, bl, fs, ls, sb, fe;
    int gp;
    if (r) begin
      m_pix = 0; m_line = 0; m_scale = 1;
      held_sl = 0; held_cl = 0; held_gl = 0;
      e.v = pack(!HSP, !VSP, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e.rst = 1'b1;
    end else begin
      m_pix++;
      if (m_pix == HT) begin
        m_pix = 0;
        m_line = (m_line == VT - 1) ? 0 : m_line + 1;
        if (m_line == 0) begin
          m_scale = (vs == 2'd1) ? 2 : (vs == 2'd2) ? 3 : 1;
          m_fr++;
          nfs_exp++;
        end
      end
      win = (m_line >= WY) && (m_line < WY + WH);
      hs  = (m_pix >= HA + HFP && m_pix < HA + HFP + HSW) ? HSP : !HSP;
      vsy = (m_line >= VA + VFP && m_line < VA + VFP + VSW) ? VSP : !VSP;
      hb  = m_pix >= HA;
      vb  = m_line >= VA;
      bl  = hb || vb;
      ls  = m_pix == 0;
      fs  = ls && (m_line == 0);
      fe  = win && (m_pix >= WX - LD) && (m_pix < WX + WW - LD);
      sb  = !bl && !(win && m_pix >= WX && m_pix < WX + WW);
      gp  = 0;
      if (win) begin
        gp = m_pix - (WX - LD);
        if (gp < 0) gp = 0;
        if (gp > WW) gp = WW;
        held_sl = (m_line - WY) % CH;
        held_cl = (m_line - WY) / CH;
        held_gl = (m_line - WY) / m_scale;
      end
      e.v = pack(hs, vsy, hb, vb, bl, fs, ls, sb, fe, m_pix, m_line,
                 gp % CW, gp / CW, held_sl, held_cl, gp, held_gl);
      e.rst = 1'b0;
    end
    sbq.push_back(e);
  endtask

  task automatic step(input bit r, input logic [1:0] vs);
    @(negedge pixel_clock);
    reset = r;
    vif.v_scale = vs;
    @(posedge pixel_clock);
    model_step(r, vs);
  endtask

  // Compare DUT outputs against the queued expectation and track the frame period
  always @(negedge pixel_clock) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      check("outputs", observed(), e.v);
      if (e.rst) begin
        anchor = chk_cyc;
      end else if (vif.frame_start === 1'b1) begin
        nfs_obs++;
        if (anchor >= 0) check("frame_period", 80'(chk_cyc - anchor), 80'(HT * VT));
        anchor = chk_cyc;
      end
      chk_cyc++;
    end
  end

  initial begin
    bit done;
    bit mid_rst_done;
    logic [1:0] vs;
    bit r;
    reset = 1'b1;
    vif.v_scale = 2'd0;
    m_fr = 0;
    done = 1'b0;
    mid_rst_done = 1'b0;

    for (int i = 0; i < 3; i++) step(1'b1, 2'd0);
    m_fr = 0;

    // frame 0: 1x after reset, request 3x
    // frame 1: 3x, request 1x
    // frame 2: 1x, switch request 0 -> 1 mid-window (must not affect this frame)
    // frame 3: 2x, one-cycle reset mid-frame, then frames 4 (1x, request 3=1x), 5 (1x), 6 (2x)
    for (int n = 0; n < STEP_LIMIT && !done; n++) begin
      r = 1'b0;
      case (m_fr)
        0:       vs = 2'd2;
        1:       vs = 2'd0;
        2:       vs = (m_line >= 10) ? 2'd1 : 2'd0;
        3:       vs = 2'd1;
        4:       vs = 2'd3;
        default: vs = 2'd1;
      endcase
      if (m_fr == 3 && !mid_rst_done && m_line == 20 && m_pix == 30) begin
        r = 1'b1;
        mid_rst_done = 1'b1;
      end
      step(r, vs);
      if (r) m_fr = 4;
      if (m_fr == 6 && m_line == 25) done = 1'b1;
    end
    if (!done) check("run_bound", 80'(m_fr), 80'(6));

    @(negedge pixel_clock);
    @(negedge pixel_clock);
    #1;
    check("sb_drain", 80'(sbq.size()), 80'(0));
    check("fs_count", 80'(nfs_obs), 80'(nfs_exp));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
